// File: rtl/seq_tracker.sv
// Locks onto the 5-bit sequence s' = ((2s-1) mod 32) ^ (s & 7) and flags breaks while locked.
// Define SEQ_TRACKER_ASSERT_EN to compile in embedded consistency assertions.
module seq_tracker #(
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [4:0]       in_state,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       predicted,
    output logic             pred_valid
);

    localparam int unsigned MW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [MW-1:0]    match_cnt, match_cnt_nxt;
    logic             locked_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic [4:0]       predicted_nxt;
    logic             pred_valid_nxt;
    logic             sample_hit;

    function automatic logic [4:0] seq_next(input logic [4:0] s);
        return ({s[3:0], 1'b0} - 5'd1) ^ {2'b00, s[2:0]};
    endfunction

    assign sample_hit = (in_state == predicted);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            match_cnt  <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            predicted  <= 5'd0;
            pred_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_cnt_nxt;
            locked     <= locked_nxt;
            err        <= err_nxt;
            err_count  <= err_count_nxt;
            predicted  <= predicted_nxt;
            pred_valid <= pred_valid_nxt;
        end
    end

    // Next-state logic; err defaults low so it never lasts more than one cycle.
    always_comb begin
        state_nxt      = state;
        match_cnt_nxt  = match_cnt;
        locked_nxt     = locked;
        err_nxt        = 1'b0;
        err_count_nxt  = err_count;
        predicted_nxt  = predicted;
        pred_valid_nxt = pred_valid;

        if (in_valid) begin
            predicted_nxt  = seq_next(in_state);
            pred_valid_nxt = 1'b1;
            case (state)
                IDLE: begin
                    state_nxt     = TRACK;
                    match_cnt_nxt = '0;
                    locked_nxt    = 1'b0;
                end
                TRACK: begin
                    if (sample_hit) begin
                        if (match_cnt == MW'(LOCK_N - 1)) begin
                            state_nxt     = LOCKED;
                            match_cnt_nxt = MW'(LOCK_N);
                            locked_nxt    = 1'b1;
                        end else begin
                            match_cnt_nxt = match_cnt + MW'(1);
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!sample_hit) begin
                        state_nxt     = TRACK;
                        match_cnt_nxt = '0;
                        locked_nxt    = 1'b0;
                        err_nxt       = 1'b1;
                        if (err_count != CNT_MAX) begin
                            err_count_nxt = err_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    match_cnt_nxt = '0;
                    locked_nxt    = 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_TRACKER_ASSERT_EN
    logic [CNT_W-1:0] err_count_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_prev <= '0;
        end else begin
            err_count_prev <= err_count;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(err && locked));
            assert (!locked || pred_valid);
            assert (err_count >= err_count_prev);
            assert (state inside {IDLE, TRACK, LOCKED});
        end
    end
`endif

endmodule

// File: tb/tb_seq_tracker.sv
// Randomized and directed bench for seq_tracker against a run-length reference model.
module tb_seq_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_state = 5'd0;

    logic       locked, err, pred_valid;
    logic [7:0] err_count;
    logic [4:0] predicted;
    logic       locked2, err2, pred_valid2;
    logic [1:0] err_count2;
    logic [4:0] predicted2;

    int n_checks = 0;
    int n_errors = 0;

    // Model: length of the current run of correct successors, last sample, error tally.
    int m_run, m_last, m_errs;
    bit m_pv, m_err;

    seq_tracker #(.LOCK_N(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state),
        .locked(locked), .err(err), .err_count(err_count),
        .predicted(predicted), .pred_valid(pred_valid)
    );

    seq_tracker #(.LOCK_N(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state),
        .locked(locked2), .err(err2), .err_count(err_count2),
        .predicted(predicted2), .pred_valid(pred_valid2)
    );

    always #5 clk = ~clk;

    function automatic int mf(input int s);
        return (((2 * s - 1) + 32) % 32) ^ (s % 8);
    endfunction

    function automatic int exp_pred();
        return m_pv ? mf(m_last) : 0;
    endfunction

    function automatic int exp_locked();
        return (m_pv && m_run >= 3) ? 1 : 0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_last = 0; m_errs = 0; m_pv = 0; m_err = 0;
    endtask

    task automatic model_accept(input int s);
        if (!m_pv) begin
            m_run = 0;
            m_pv  = 1;
        end else if (s == mf(m_last)) begin
            m_run++;
        end else begin
            if (m_run >= 3) begin
                m_err = 1;
                m_errs++;
            end
            m_run = 0;
        end
        m_last = s;
    endtask

    task automatic step(input logic v, input logic [4:0] s);
        in_valid = v;
        in_state = s;
        @(posedge clk);
        m_err = 0;
        if (v && rst_n) model_accept(int'(s));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({locked, err, pred_valid, predicted, err_count} !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got l=%b e=%b pv=%b p=%0d c=%0d, want all 0",
                     locked, err, pred_valid, predicted, err_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_lock_basic();
        logic [4:0] seq [4] = '{5'd27, 5'd22, 5'd13, 5'd28};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            n_checks++;
            if (locked !== (i == 3)) begin
                n_errors++;
                $display("FAIL lock_basic_locked[%0d]: got %b want %b", i, locked, i == 3);
            end
        end
        n_checks++;
        if (predicted !== 5'd19 || err_count !== 8'd0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL lock_basic_out: got p=%0d c=%0d e=%b want p=19 c=0 e=0",
                     predicted, err_count, err);
        end
    endtask

    task automatic test_break();
        step(1'b1, 5'd19);
        step(1'b1, 5'd6);
        n_checks++;
        if (locked !== 1'b1 || predicted !== 5'd13) begin
            n_errors++;
            $display("FAIL break_prelock: got l=%b p=%0d want l=1 p=13", locked, predicted);
        end
        step(1'b1, 5'd5);
        n_checks++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || predicted !== 5'd12) begin
            n_errors++;
            $display("FAIL break_err: got e=%b c=%0d l=%b p=%0d want e=1 c=1 l=0 p=12",
                     err, err_count, locked, predicted);
        end
        step(1'b0, 5'd0);
        n_checks++;
        if (err !== 1'b0 || err_count !== 8'd1 || err_count2 !== 2'd1) begin
            n_errors++;
            $display("FAIL break_pulse_end: got e=%b c=%0d c2=%0d want e=0 c=1 c2=1",
                     err, err_count, err_count2);
        end
    endtask

    task automatic test_idle_gaps();
        logic [4:0] seq [4] = '{5'd27, 5'd22, 5'd13, 5'd28};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            for (int g = 0; g < 4; g++) begin
                step(1'b0, 5'($urandom_range(31)));
                n_checks++;
                if (err !== 1'b0 || locked !== (i == 3)) begin
                    n_errors++;
                    $display("FAIL idle_gap[%0d.%0d]: got e=%b l=%b want e=0 l=%b",
                             i, g, err, locked, i == 3);
                end
            end
        end
        n_checks++;
        if (predicted !== 5'd19 || err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL idle_gap_final: got p=%0d c=%0d want p=19 c=0", predicted, err_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 5'd0);
        n_checks++;
        if (predicted !== 5'd31 || pred_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_f0: got p=%0d pv=%b want p=31 pv=1", predicted, pred_valid);
        end
        step(1'b1, 5'd31);
        n_checks++;
        if (predicted !== 5'd26 || locked !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_f31: got p=%0d l=%b want p=26 l=0", predicted, locked);
        end
        step(1'b1, 5'd26);
        step(1'b1, 5'd17);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_lock: got l=%b want 1", locked);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1'b1, 5'd27);
        for (int e = 0; e < 5; e++) begin
            step(1'b1, 5'd22);
            step(1'b1, 5'd13);
            step(1'b1, 5'd28);
            n_checks++;
            if (locked2 !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_lock[%0d]: got l2=%b want 1", e, locked2);
            end
            step(1'b1, 5'd27);
            n_checks++;
            if (err2 !== 1'b1 || err_count2 !== 2'(sat(e + 1, 3)) || err_count !== 8'(e + 1)) begin
                n_errors++;
                $display("FAIL sat_err[%0d]: got e2=%b c2=%0d c=%0d want e2=1 c2=%0d c=%0d",
                         e, err2, err_count2, err_count, sat(e + 1, 3), e + 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 5'd27); step(1'b1, 5'd22); step(1'b1, 5'd13); step(1'b1, 5'd28);
        step(1'b1, 5'd27);
        step(1'b1, 5'd22); step(1'b1, 5'd13); step(1'b1, 5'd28);
        n_checks++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL async_prelock: got l=%b c=%0d want l=1 c=1", locked, err_count);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({locked, err, pred_valid, predicted, err_count} !== 16'd0) begin
            n_errors++;
            $display("FAIL async_lock_clear: got l=%b e=%b pv=%b p=%0d c=%0d want all 0",
                     locked, err, pred_valid, predicted, err_count);
        end
        in_valid = 1'b1;
        in_state = 5'd27;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({locked, pred_valid, predicted} !== 7'd0) begin
            n_errors++;
            $display("FAIL async_ignore: got l=%b pv=%b p=%0d want all 0", locked, pred_valid, predicted);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 5'd27); step(1'b1, 5'd22); step(1'b1, 5'd13); step(1'b1, 5'd28);
        step(1'b1, 5'd5);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL async_pre_err: got e=%b want 1", err);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({err, locked, pred_valid, err_count} !== 11'd0) begin
            n_errors++;
            $display("FAIL async_err_clear: got e=%b l=%b pv=%b c=%0d want all 0",
                     err, locked, pred_valid, err_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 5'd22);
        n_checks++;
        if (predicted !== 5'd13 || pred_valid !== 1'b1 || locked !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL async_first_sample: got p=%0d pv=%b l=%b e=%b want p=13 pv=1 l=0 e=0",
                     predicted, pred_valid, locked, err);
        end
    endtask

    task automatic test_random();
        logic [4:0] s;
        logic       v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(3) != 0);
            if (m_pv && $urandom_range(4) != 0) s = 5'(mf(m_last));
            else s = 5'($urandom_range(31));
            step(v, s);
            n_checks++;
            if (locked !== 1'(exp_locked()) || err !== m_err || pred_valid !== m_pv ||
                predicted !== 5'(exp_pred())) begin
                n_errors++;
                $display("FAIL random_out[%0d]: got l=%b e=%b pv=%b p=%0d want l=%0d e=%b pv=%b p=%0d",
                         i, locked, err, pred_valid, predicted, exp_locked(), m_err, m_pv, exp_pred());
            end
            n_checks++;
            if (err_count !== 8'(sat(m_errs, 255)) || err_count2 !== 2'(sat(m_errs, 3)) ||
                err2 !== m_err) begin
                n_errors++;
                $display("FAIL random_cnt[%0d]: got c=%0d c2=%0d e2=%b want c=%0d c2=%0d e2=%b",
                         i, err_count, err_count2, err2, sat(m_errs, 255), sat(m_errs, 3), m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_basic();
        test_break();
        test_idle_gaps();
        test_wrap();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_tracker.md
SEQ_TRACKER -- requirements
Module: seq_tracker

Interface
REQ-001 SHALL have parameter LOCK_N, default 3, consecutive correct samples needed to declare lock (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, width of the error counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_state carries a sample this cycle.
REQ-006 SHALL have port in_state  input  5  observed value of the 5-bit sequence generator.
REQ-007 SHALL have port locked  output  1  tracker is locked onto a valid sequence.
REQ-008 SHALL have port err  output  1  one-cycle pulse on a sequence break while locked.
REQ-009 SHALL have port err_count  output  CNT_W  saturating count of err pulses.
REQ-010 SHALL have port predicted  output  5  expected next sample, f(last accepted sample).
REQ-011 SHALL have port pred_valid  output  1  predicted is meaningful (at least one sample accepted).

Function
REQ-012 SHALL define f(s) = ((2*s - 1) mod 32) XOR (s AND 7), all 5-bit arithmetic with wrap-around (f(0)=31).
REQ-013 SHALL accept a sample only on posedge clk with in_valid=1; in_valid=0 cycles hold all state, with no timeout.
REQ-014 SHALL implement FSM states IDLE, TRACK, LOCKED, plus an internal match counter of width ceil(log2(LOCK_N+1)).
REQ-015 IDLE: on accepted sample -> TRACK, match_cnt=0, predicted=f(sample), pred_valid=1.
REQ-016 TRACK, sample==predicted: match_cnt+1; if it reaches LOCK_N -> LOCKED, locked=1; predicted=f(sample).
REQ-017 TRACK, sample!=predicted: stay TRACK, match_cnt=0, predicted=f(sample), no err.
REQ-018 LOCKED, sample==predicted: stay LOCKED, predicted=f(sample).
REQ-019 LOCKED, sample!=predicted: -> TRACK, locked=0, match_cnt=0, predicted=f(sample), err=1 for exactly the next cycle, err_count+1.
REQ-020 err_count SHALL saturate at 2^CNT_W-1 and never wrap or decrease except on reset.
REQ-021 All outputs SHALL be registered; a change caused by a sample accepted at edge N is visible after edge N, with no combinational path from inputs.
REQ-022 err SHALL be 0 in every cycle not immediately following a locked mismatch, including back-to-back valid cycles.

Reset
REQ-023 rst_n=0 SHALL immediately force FSM=IDLE, match_cnt=0, locked=0, err=0, err_count=0, predicted=0, pred_valid=0, independent of clk.
REQ-024 Reset asserted mid-lock or mid-err-pulse SHALL discard all history; the first sample after release is treated as an IDLE sample.
REQ-025 Samples presented while rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro SEQ_TRACKER_ASSERT_EN SHALL, when defined, compile in embedded immediate assertions: err implies !locked; locked implies pred_valid; err_count never decreases while rst_n=1; FSM state is always one of the three legal encodings.
REQ-027 Without SEQ_TRACKER_ASSERT_EN the assertions SHALL be absent and functional behaviour SHALL be identical.

Verification
REQ-028 Reset, then samples 27,22,13,28 on consecutive cycles -> locked=1 after the edge accepting 28, predicted=19, err_count=0.
REQ-029 Locked on 13,28,19,6 cycle, feed 5 when 13 expected -> err=1 for one cycle, err_count=1, locked=0, predicted=12.
REQ-030 Samples 27,22,13,28 with 4 idle in_valid=0 cycles between each -> same lock result as REQ-028; no err.
REQ-031 Samples 0 then 31 -> treated as a match (match_cnt=1), predicted=26.
REQ-032 CNT_W=2, five lock-then-break episodes -> err_count reaches 3 and holds at 3; err still pulses each time.
REQ-033 Drop rst_n asynchronously while locked and mid-err-pulse -> locked, err, err_count, pred_valid reach 0 before the next clk edge.
